servo_sequencer: RTL and testbench
==================================

// Module: servo_sequencer
// PURPOSE
//  Multi-channel successor to the single-servo song timer. Each channel rests at
//  REST_ANGLE; on an MCU start edge it swings to ACTIVE_ANGLE for a runtime-programmed
//  hold time, then stays at rest through a lockout window before it re-arms.
//  Sits between the MCU start lines and the per-servo PWM generators.
// PARAMETERS
//  NCH           2           number of independent servo channels
//  ANGLE_W       10          width of each channel's angle field
//  CNT_W         32          width of the hold/cooldown counters and hold_cycles
//  REST_ANGLE    10'd180     angle driven when a channel is idle or in cooldown
//  ACTIVE_ANGLE  10'd0       angle driven during hold (0 corresponds to -90 deg)
//  COOL_CYCLES   24000000    lockout cycles after hold; 0 = no cooldown
//  RETRIGGER     1           1: start edge during hold restarts hold; 0: ignored
// PORTS
//  clk          in   1            system clock (single clock domain)
//  reset        in   1            asynchronous, active-high reset
//  song_start   in   NCH          per-channel start from MCU, asynchronous level
//  hold_cycles  in   CNT_W        hold length in clk cycles, sampled at trigger
//  angle        out  NCH*ANGLE_W  channel i at [i*ANGLE_W +: ANGLE_W]
//  busy         out  NCH          1 while channel is in HOLD or COOL
//  done         out  NCH          one-cycle pulse when a hold completes
// BEHAVIOUR
//  - Reset (async): all channels IDLE; angle = REST_ANGLE each; busy = 0; done = 0;
//    synchronizer/edge flops and counters = 0. Takes effect mid-operation immediately.
//  - Input: per channel 2-flop synchronizer s1,s2, plus a delay flop s3.
//    edge = s2 & ~s3. Only rising edges trigger; a held-high level triggers once.
//  - Latency: song_start first sampled high at edge k -> edge true in cycle k+1 ->
//    state HOLD and angle = ACTIVE_ANGLE after edge k+2.
//  - Per-channel FSM, states IDLE / HOLD / COOL, all channels independent:
//    IDLE: on edge, load cnt = max(hold_cycles,1)-1 and go to HOLD.
//    HOLD: if cnt==0 and no retrigger, go to COOL (cnt=COOL_CYCLES-1), or to IDLE
//      if COOL_CYCLES==0; assert done the next cycle. Otherwise cnt decrements.
//      With RETRIGGER=1, an edge reloads cnt from current hold_cycles and stays in HOLD.
//      An edge coinciding with cnt==0 retriggers: no done pulse.
//      With RETRIGGER=0, edges in HOLD are ignored.
//    COOL: cnt decrements; at cnt==0 go to IDLE. Edges are ignored (lockout).
//  - HOLD lasts exactly max(H,1) cycles (H = hold_cycles when sampled).
//    COOL lasts exactly COOL_CYCLES cycles.
//  - done: registered; high for exactly 1 cycle, in the cycle after the last HOLD cycle.
//  - Outputs:
//    angle = ACTIVE_ANGLE in HOLD, REST_ANGLE otherwise; decoded from state (no extra lag).
//    busy = (state != IDLE).
//  - Counters never wrap. hold_cycles is captured only at load; later changes do not
//    affect the running hold.
//  - Simultaneous edges on several channels are all accepted in the same cycle.
// TESTING  (NCH=2, COOL_CYCLES=3, RETRIGGER=1 unless stated)
//  1 Reset: assert reset mid-HOLD -> angle = {180,180} and busy = 0 in the same
//    cycle, asynchronously; done stays 0.
//  2 Basic: hold_cycles=5, pulse song_start[0] -> ch0 angle=0 from k+2 for exactly
//    5 cycles; done[0] pulses once; busy[0] high for 8 cycles; ch1 stays 180.
//  3 Retrigger: hold=5, second ch0 edge on the 3rd HOLD cycle -> HOLD totals 8 cycles;
//    one done pulse. Rebuild with RETRIGGER=0 -> HOLD stays 5 cycles.
//  4 Lockout: edge during COOL -> ignored, returns to IDLE on schedule.
//    An edge 1 cycle after IDLE -> new HOLD.
//  5 Boundaries: hold_cycles=0 -> 1-cycle HOLD. song_start held high 100 cycles ->
//    a single trigger. Edge coinciding with the final HOLD cycle -> retrigger, no done.
//  6 Concurrency: both channels triggered in the same cycle, with hold 4 vs 7 loaded
//    at different times -> independent angles/done; hold_cycles changed mid-hold is
//    ignored.

Source files
------------

// File: rtl/servo_sequencer.sv
// ---------------------------------------------------------------------------
// servo_sequencer
//   Multi-channel servo swing sequencer. Each channel sits at REST_ANGLE until
//   its MCU start line shows a rising edge, swings to ACTIVE_ANGLE for a hold
//   time sampled from hold_cycles, then stays at rest through a lockout
//   (cooldown) window before it accepts another start.
//
// Ports
//   clk          system clock (single domain)
//   reset        asynchronous, active-high reset
//   song_start   per-channel start request from the MCU (asynchronous level)
//   hold_cycles  hold length in clk cycles, captured when a channel triggers
//   angle        per-channel angle, channel i at [i*ANGLE_W +: ANGLE_W]
//   busy         per-channel, high while the channel is holding or cooling
//   done         per-channel one-cycle pulse after the last hold cycle
// ---------------------------------------------------------------------------
module servo_sequencer #(
  parameter int                 NCH          = 2,
  parameter int                 ANGLE_W      = 10,
  parameter int                 CNT_W        = 32,
  parameter logic [ANGLE_W-1:0] REST_ANGLE   = 10'd180,
  parameter logic [ANGLE_W-1:0] ACTIVE_ANGLE = 10'd0,
  parameter int                 COOL_CYCLES  = 24000000,
  parameter int                 RETRIGGER    = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCH-1:0]         song_start,
  input  logic [CNT_W-1:0]       hold_cycles,
  output logic [NCH*ANGLE_W-1:0] angle,
  output logic [NCH-1:0]         busy,
  output logic [NCH-1:0]         done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_COOL = 2'd2
  } state_t;

  // Cooldown reload value; a zero-length cooldown skips the COOL state entirely.
  localparam logic [CNT_W-1:0] COOL_LOAD =
    (COOL_CYCLES > 0) ? CNT_W'(COOL_CYCLES - 1) : '0;

  logic [NCH-1:0]   sync1;
  logic [NCH-1:0]   sync2;
  logic [NCH-1:0]   sync3;
  logic [NCH-1:0]   start_edge;
  logic [CNT_W-1:0] hold_load;

  state_t           state [NCH];
  logic [CNT_W-1:0] cnt   [NCH];

  // Two flops bring the asynchronous start lines into the clk domain; the
  // third flop remembers the previous synchronized level for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= song_start;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign start_edge = sync2 & ~sync3;

  // A zero hold request is treated as a one-cycle hold, so the counter load
  // is max(hold_cycles,1)-1 and can never underflow.
  assign hold_load = (hold_cycles == '0) ? '0 : hold_cycles - CNT_W'(1);

  // Per-channel IDLE/HOLD/COOL sequencing. The counter holds the number of
  // cycles remaining after the current one, so a state with load N-1 lasts N
  // cycles. done is raised on the transition out of HOLD so it appears in the
  // cycle right after the last hold cycle; a retrigger on that final cycle
  // takes priority and suppresses the pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        state[i] <= ST_IDLE;
        cnt[i]   <= '0;
      end
      done <= '0;
    end else begin
      done <= '0;
      for (int i = 0; i < NCH; i++) begin
        case (state[i])
          ST_IDLE: begin
            if (start_edge[i]) begin
              state[i] <= ST_HOLD;
              cnt[i]   <= hold_load;
            end
          end
          ST_HOLD: begin
            if (start_edge[i] && (RETRIGGER != 0)) begin
              cnt[i] <= hold_load;
            end else if (cnt[i] == '0) begin
              done[i] <= 1'b1;
              if (COOL_CYCLES == 0) begin
                state[i] <= ST_IDLE;
              end else begin
                state[i] <= ST_COOL;
                cnt[i]   <= COOL_LOAD;
              end
            end else begin
              cnt[i] <= cnt[i] - CNT_W'(1);
            end
          end
          ST_COOL: begin
            if (cnt[i] == '0) begin
              state[i] <= ST_IDLE;
            end else begin
              cnt[i] <= cnt[i] - CNT_W'(1);
            end
          end
          default: begin
            state[i] <= ST_IDLE;
            cnt[i]   <= '0;
          end
        endcase
      end
    end
  end

  // Angle and busy decode straight from the registered state, so they follow
  // the state (and an asynchronous reset) without an extra cycle of lag.
  always_comb begin
    angle = '0;
    busy  = '0;
    for (int i = 0; i < NCH; i++) begin
      angle[i*ANGLE_W +: ANGLE_W] = (state[i] == ST_HOLD) ? ACTIVE_ANGLE : REST_ANGLE;
      busy[i]                     = (state[i] != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_servo_sequencer.sv
// ---------------------------------------------------------------------------
// tb_servo_sequencer
//   Directed bench for servo_sequencer with NCH=2, COOL_CYCLES=3. Two
//   instances are used: one with RETRIGGER=1 (channels 0,1) and one with
//   RETRIGGER=0 (tracked as channels 2,3). Stimulus pushes the hand-computed
//   output transitions {cycle, angle, busy, done} per channel into a queue;
//   a monitor watches every channel at the falling edge and pops/compares an
//   expected entry whenever that channel's outputs change.
// ---------------------------------------------------------------------------
module tb_servo_sequencer;

  localparam logic [9:0] REST = 10'd180;
  localparam logic [9:0] ACT  = 10'd0;

  logic        clk;
  logic        reset;
  logic [1:0]  song_start;
  logic [1:0]  start_nr;
  logic [31:0] hold_cycles;
  logic [19:0] angle;
  logic [1:0]  busy;
  logic [1:0]  done;
  logic [19:0] angle_nr;
  logic [1:0]  busy_nr;
  logic [1:0]  done_nr;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int         ch;
    int         cyc;
    logic [9:0] ang;
    logic       busy;
    logic       done;
  } ev_t;

  ev_t        exp_q[$];
  logic [11:0] prev_st [4];

  servo_sequencer #(
    .NCH(2), .ANGLE_W(10), .CNT_W(32), .REST_ANGLE(10'd180),
    .ACTIVE_ANGLE(10'd0), .COOL_CYCLES(3), .RETRIGGER(1)
  ) dut (
    .clk(clk), .reset(reset), .song_start(song_start), .hold_cycles(hold_cycles),
    .angle(angle), .busy(busy), .done(done)
  );

  servo_sequencer #(
    .NCH(2), .ANGLE_W(10), .CNT_W(32), .REST_ANGLE(10'd180),
    .ACTIVE_ANGLE(10'd0), .COOL_CYCLES(3), .RETRIGGER(0)
  ) dut_nr (
    .clk(clk), .reset(reset), .song_start(start_nr), .hold_cycles(hold_cycles),
    .angle(angle_nr), .busy(busy_nr), .done(done_nr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index: value n means the n-th rising edge has occurred.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] get_status(int ch);
    case (ch)
      0:       return {angle[9:0],     busy[0],    done[0]};
      1:       return {angle[19:10],   busy[1],    done[1]};
      2:       return {angle_nr[9:0],  busy_nr[0], done_nr[0]};
      default: return {angle_nr[19:10], busy_nr[1], done_nr[1]};
    endcase
  endfunction

  task automatic compare_event(int ch, logic [11:0] st);
    int  idx;
    ev_t e;
    idx = -1;
    for (int j = 0; j < exp_q.size(); j++) begin
      if (exp_q[j].ch == ch) begin
        idx = j;
        break;
      end
    end
    checks++;
    if (idx < 0) begin
      errors++;
      $display("[TB] FAIL unexpected_ch%0d: got angle=%0d busy=%0b done=%0b at cycle %0d, required no change",
               ch, st[11:2], st[1], st[0], cyc);
    end else begin
      e = exp_q[idx];
      exp_q.delete(idx);
      if (e.cyc != cyc || st !== {e.ang, e.busy, e.done}) begin
        errors++;
        $display("[TB] FAIL event_ch%0d: got angle=%0d busy=%0b done=%0b at cycle %0d, required angle=%0d busy=%0b done=%0b at cycle %0d",
                 ch, st[11:2], st[1], st[0], cyc, e.ang, e.busy, e.done, e.cyc);
      end
    end
  endtask

  // Monitor: compare on every output change of every tracked channel.
  always @(negedge clk) begin
    logic [11:0] st;
    for (int ch = 0; ch < 4; ch++) begin
      st = get_status(ch);
      if (st !== prev_st[ch]) begin
        compare_event(ch, st);
        prev_st[ch] = st;
      end
    end
  end

  task automatic push_ev(int ch, int c, logic [9:0] a, logic b, logic d);
    ev_t e;
    e.ch = ch; e.cyc = c; e.ang = a; e.busy = b; e.done = d;
    exp_q.push_back(e);
  endtask

  // Trigger sampled at rising edge k, total hold length len, cooldown 3:
  // hold from k+2, done pulse at k+2+len, idle again at k+5+len.
  task automatic push_hold(int ch, int k, int len);
    push_ev(ch, k + 2,       ACT,  1'b1, 1'b0);
    push_ev(ch, k + 2 + len, REST, 1'b1, 1'b1);
    push_ev(ch, k + 3 + len, REST, 1'b1, 1'b0);
    push_ev(ch, k + 5 + len, REST, 1'b0, 1'b0);
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  // One-cycle start pulse; it is sampled at rising edge cyc+1.
  task automatic applyStimulus(logic [1:0] m, logic [1:0] m_nr);
    song_start = m;
    start_nr   = m_nr;
    tick(1);
    song_start = 2'b00;
    start_nr   = 2'b00;
  endtask

  task automatic checkOutput(string name, logic [19:0] exp_angle, logic [1:0] exp_busy,
                             logic [1:0] exp_done);
    checks++;
    if (angle !== exp_angle || busy !== exp_busy || done !== exp_done) begin
      errors++;
      $display("[TB] FAIL %s: got angle={%0d,%0d} busy=%b done=%b, required angle={%0d,%0d} busy=%b done=%b",
               name, angle[19:10], angle[9:0], busy, done,
               exp_angle[19:10], exp_angle[9:0], exp_busy, exp_done);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at time limit, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    for (int i = 0; i < 4; i++) prev_st[i] = {REST, 2'b00};
    reset       = 1'b1;
    song_start  = 2'b00;
    start_nr    = 2'b00;
    hold_cycles = 32'd5;

    tick(3);
    checkOutput("reset_state", {REST, REST}, 2'b00, 2'b00);
    reset = 1'b0;
    tick(2);

    $display("[TB] basic hold of 5 on channel 0");
    hold_cycles = 32'd5;
    k = cyc + 1;
    push_hold(0, k, 5);
    applyStimulus(2'b01, 2'b00);
    tick(15);

    $display("[TB] retrigger on 3rd hold cycle, both RETRIGGER settings");
    hold_cycles = 32'd5;
    k = cyc + 1;
    push_hold(0, k, 8);
    push_hold(2, k, 5);
    applyStimulus(2'b01, 2'b01);
    tick(2);
    applyStimulus(2'b01, 2'b01);
    tick(20);

    $display("[TB] lockout during cooldown, then edge in first idle cycle");
    hold_cycles = 32'd2;
    k = cyc + 1;
    push_hold(0, k, 2);
    push_hold(0, k + 6, 2);
    applyStimulus(2'b01, 2'b00);
    tick(3);
    applyStimulus(2'b01, 2'b00);
    tick(1);
    applyStimulus(2'b01, 2'b00);
    tick(20);

    $display("[TB] zero hold request");
    hold_cycles = 32'd0;
    k = cyc + 1;
    push_hold(0, k, 1);
    applyStimulus(2'b01, 2'b00);
    tick(15);

    $display("[TB] start held high for 100 cycles");
    hold_cycles = 32'd3;
    k = cyc + 1;
    push_hold(0, k, 3);
    song_start = 2'b01;
    tick(100);
    song_start = 2'b00;
    tick(10);

    $display("[TB] edge on final hold cycle");
    hold_cycles = 32'd5;
    k = cyc + 1;
    push_hold(0, k, 10);
    push_hold(2, k, 5);
    applyStimulus(2'b01, 2'b01);
    tick(4);
    applyStimulus(2'b01, 2'b01);
    tick(25);

    $display("[TB] both channels in the same cycle");
    hold_cycles = 32'd4;
    k = cyc + 1;
    push_hold(0, k, 4);
    push_hold(1, k, 4);
    applyStimulus(2'b11, 2'b00);
    tick(15);

    $display("[TB] staggered channels with hold_cycles changed mid-hold");
    hold_cycles = 32'd4;
    k = cyc + 1;
    push_hold(0, k, 4);
    push_hold(1, k + 2, 7);
    applyStimulus(2'b01, 2'b00);
    tick(1);
    applyStimulus(2'b10, 2'b00);
    hold_cycles = 32'd7;
    tick(3);
    hold_cycles = 32'd1;
    tick(20);

    $display("[TB] asynchronous reset in the middle of a hold");
    hold_cycles = 32'd5;
    k = cyc + 1;
    push_ev(0, k + 2, ACT, 1'b1, 1'b0);
    applyStimulus(2'b01, 2'b00);
    tick(3);
    checkOutput("mid_hold", {REST, ACT}, 2'b01, 2'b00);
    push_ev(0, cyc + 1, REST, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    checkOutput("async_reset", {REST, REST}, 2'b00, 2'b00);
    tick(2);
    reset = 1'b0;
    tick(8);

    while (exp_q.size() > 0) begin
      ev_t e;
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL missing_ch%0d: got no change, required angle=%0d busy=%0b done=%0b at cycle %0d",
               e.ch, e.ang, e.busy, e.done, e.cyc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
